// File: rtl/qspi_mem_responder.sv
// QSPI quad-mode memory target: oversamples cs/sck/sd on clk_i and serves EB reads and 38 writes from a byte array.
// Latency: read nibbles appear on sd_o 3 clk_i cycles after the raw sck fall (2-FF sync + registered output).
// Backpressure: none; the controller sets the pace via sck, and the memory is updated on the second write nibble's rise.
module qspi_mem_responder #(
  parameter int         DEPTH  = 4096,
  parameter int         DUMMY  = 4,
  parameter logic [7:0] CMD_RD = 8'hEB,
  parameter logic [7:0] CMD_WR = 8'h38
) (
  input  logic                     clk_i,
  input  logic                     rst_in,
  input  logic                     cs_in,
  input  logic                     sck_i,
  input  logic [3:0]               sd_i,
  output logic [3:0]               sd_o,
  output logic [3:0]               sd_oen_o,
  input  logic                     load_we_i,
  input  logic [$clog2(DEPTH)-1:0] load_adr_i,
  input  logic [7:0]               load_dat_i,
  output logic                     busy_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_RDATA,
    S_WDATA,
    S_IGNORE
  } state_t;

  // Synchronizer stages and previous sck for edge detection
  logic          r_cs_s1, r_cs_s2;
  logic          r_sck_s1, r_sck_s2, r_sck_d;
  logic [3:0]    r_sd_s1, r_sd_s2;

  // Frame state
  state_t        r_state;
  logic [7:0]    r_cnt;
  logic [7:0]    r_cmd;
  logic [AW-1:0] r_addr;
  logic [3:0]    r_hi;
  logic [3:0]    r_lo;
  logic          r_phase;

  // Byte array (not reset) and its single write port
  logic [7:0]    r_mem [DEPTH];
  logic          w_mem_we;
  logic [AW-1:0] w_mem_adr;
  logic [7:0]    w_mem_dat;
  logic [7:0]    w_rd_byte;

  logic          w_rise;
  logic          w_fall;
  logic [7:0]    w_cmd_next;

  // sck edges only count while the synchronized chip select is asserted
  assign w_rise     = ~r_cs_s2 &  r_sck_s2 & ~r_sck_d;
  assign w_fall     = ~r_cs_s2 & ~r_sck_s2 &  r_sck_d;
  assign w_cmd_next = {r_cmd[3:0], r_sd_s2};
  assign w_rd_byte  = r_mem[r_addr];
  assign busy_o     = (r_state != S_IDLE);

  // Two-flop synchronizers for the asynchronous QSPI pins
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_cs_s1  <= 1'b1;
      r_cs_s2  <= 1'b1;
      r_sck_s1 <= 1'b0;
      r_sck_s2 <= 1'b0;
      r_sck_d  <= 1'b0;
      r_sd_s1  <= 4'h0;
      r_sd_s2  <= 4'h0;
    end else begin
      r_cs_s1  <= cs_in;
      r_cs_s2  <= r_cs_s1;
      r_sck_s1 <= sck_i;
      r_sck_s2 <= r_sck_s1;
      r_sck_d  <= r_sck_s2;
      r_sd_s1  <= sd_i;
      r_sd_s2  <= r_sd_s1;
    end
  end

  // Frame FSM: command/address shift-in, dummy count, nibble read-out and write assembly
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_cmd    <= 8'd0;
      r_addr   <= '0;
      r_hi     <= 4'h0;
      r_lo     <= 4'h0;
      r_phase  <= 1'b0;
      sd_o     <= 4'h0;
      sd_oen_o <= 4'hF;
    end else if (r_cs_s2) begin
      // Deselect aborts any frame; a half-assembled write byte is simply dropped
      r_state  <= S_IDLE;
      r_phase  <= 1'b0;
      sd_o     <= 4'h0;
      sd_oen_o <= 4'hF;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_CMD;
          r_cnt   <= 8'd0;
          r_cmd   <= 8'd0;
          r_addr  <= '0;
          r_phase <= 1'b0;
        end
        S_CMD: begin
          if (w_rise) begin
            r_cmd <= w_cmd_next;
            if (r_cnt == 8'd1) begin
              r_cnt <= 8'd0;
              if (w_cmd_next == CMD_RD || w_cmd_next == CMD_WR) r_state <= S_ADDR;
              else                                              r_state <= S_IGNORE;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        S_ADDR: begin
          if (w_rise) begin
            // Only the last AW bits of the 24-bit address survive the shift
            r_addr <= AW'({r_addr, r_sd_s2});
            if (r_cnt == 8'd5) begin
              r_cnt   <= 8'd0;
              r_phase <= 1'b0;
              if (r_cmd == CMD_WR)  r_state <= S_WDATA;
              else if (DUMMY == 0)  r_state <= S_RDATA;
              else                  r_state <= S_DUMMY;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        S_DUMMY: begin
          if (w_rise) begin
            if (r_cnt == 8'(DUMMY - 1)) begin
              r_cnt   <= 8'd0;
              r_state <= S_RDATA;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        S_RDATA: begin
          if (w_fall) begin
            if (!r_phase) begin
              sd_o     <= w_rd_byte[7:4];
              r_lo     <= w_rd_byte[3:0];
              sd_oen_o <= 4'h0;
              r_phase  <= 1'b1;
            end else begin
              sd_o    <= r_lo;
              r_addr  <= r_addr + AW'(1);
              r_phase <= 1'b0;
            end
          end
        end
        S_WDATA: begin
          if (w_rise) begin
            if (!r_phase) begin
              r_hi    <= r_sd_s2;
              r_phase <= 1'b1;
            end else begin
              r_addr  <= r_addr + AW'(1);
              r_phase <= 1'b0;
            end
          end
        end
        S_IGNORE: begin
          r_state <= S_IGNORE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Memory write arbitration: frame writes only while selected, backdoor only while idle and deselected
  always_comb begin
    w_mem_we  = 1'b0;
    w_mem_adr = load_adr_i;
    w_mem_dat = load_dat_i;
    if (r_state == S_WDATA && w_rise && r_phase) begin
      w_mem_we  = 1'b1;
      w_mem_adr = r_addr;
      w_mem_dat = {r_hi, r_sd_s2};
    end else if (r_cs_s2 && r_state == S_IDLE && load_we_i) begin
      w_mem_we  = 1'b1;
    end
  end

  // Byte array write port; contents survive reset
  always_ff @(posedge clk_i) begin
    if (w_mem_we) r_mem[w_mem_adr] <= w_mem_dat;
  end

endmodule

// File: doc/qspi_mem_responder.md
Name: qspi_mem_responder

Overview:
- Synthesizable QSPI memory responder: the device-side end of the QSPI memory link, i.e. the counterpart of wb_qspi_mem.
- Emulates a quad-mode RAM/ROM behind one chip select. Used in FPGA prototypes and the SoC bench as the target of qspi_mem_cs_*/sck/sd.
- Runs on the system clock and oversamples the QSPI bus; holds a byte array with a preload port.

Parameters:
- DEPTH, 4096, memory size in bytes; power of two; address wraps modulo DEPTH.
- DUMMY, 4, dummy nibble cycles between address and read data.
- CMD_RD, 8'hEB, quad read command.
- CMD_WR, 8'h38, quad write command.

Ports:
- clk_i  in  1  system clock; must run at least 8x sck_i.
- rst_in  in  1  asynchronous active-low reset.
- cs_in  in  1  QSPI chip select, active low.
- sck_i  in  1  QSPI clock, mode 0.
- sd_i  in  4  QSPI data from the controller.
- sd_o  out  4  QSPI data to the controller.
- sd_oen_o  out  4  output enable, active low (1 = tristate).
- load_we_i  in  1  backdoor write strobe, honoured only while cs_in=1.
- load_adr_i  in  $clog2(DEPTH)  backdoor byte address.
- load_dat_i  in  8  backdoor byte data.
- busy_o  out  1  high while a transaction is active (state != IDLE).

Behaviour:
- Reset values: sd_o=0, sd_oen_o=4'hF, busy_o=0, state=IDLE. Memory contents are not reset.
- cs_in, sck_i and sd_i each pass through 2-FF synchronizers.
- Edges are detected on the synchronized sck: rise = sample, fall = drive. sck edges are ignored while synchronized cs is 1.
- Frame format, all quad, MSB nibble first: 2 command nibbles, 6 address nibbles (24 bits, low $clog2(DEPTH) bits used), then per-command phases.
- IDLE: cs falling -> CMD. Nibble counter and shift register are cleared.
- CMD: 2 rises shift the command in.
  - == CMD_RD or CMD_WR -> ADDR.
  - else -> IGNORE.
- ADDR: 6 rises. After the 6th: CMD_RD -> DUMMY (or straight to RDATA if DUMMY=0); CMD_WR -> WDATA.
- DUMMY: count DUMMY rises, then -> RDATA.
- RDATA:
  - On the first fall in RDATA, load byte mem[addr] into the output register, drive the high nibble, and set sd_oen_o=4'h0.
  - On the next fall, drive the low nibble and increment addr (wraps DEPTH-1 -> 0).
  - Repeat indefinitely.
  - sd_o changes no more than 3 clk_i cycles after the raw sck fall.
- WDATA:
  - Rise 1 latches the high nibble; rise 2 writes {hi,lo} to mem[addr] and increments addr (wraps).
  - sd_oen_o stays 4'hF.
- IGNORE: no output, no writes until cs rises.
- cs rising in any state -> IDLE the next cycle, sd_oen_o=4'hF. A half-received write byte is discarded. No memory side effects from an aborted command or address phase.
- Backdoor: load_we_i with synchronized cs=1 writes load_dat_i to mem[load_adr_i] in one cycle. Ignored while a frame is active.
- Reset mid-frame returns to IDLE immediately.

Test Plan:
- Preload mem[0x10..0x13]=11,22,33,44; frame EB, addr 000010, 4 dummy, 8 data nibbles -> sd_o reads 1,1,2,2,3,3,4,4; sd_oen_o=0 only during RDATA.
- Write frame 38, addr 000020, data A5 5A -> cs high; read 0x20 back -> A5,5A; mem[0x22] unchanged.
- Write at addr DEPTH-1 (000FFF) with data 01 02 -> mem[0xFFF]=01, mem[0x000]=02 (wrap).
- Command 9F followed by 20 sck cycles -> sd_oen_o stays F, no memory change, busy_o drops one cycle after cs rises.
- Write 38 addr 000030 with 3 nibbles C,3,7 then cs high -> mem[0x30]=C3, mem[0x31] unchanged.
- Assert rst_in during RDATA -> sd_oen_o=F and busy_o=0 asynchronously; the next EB frame at 0x10 returns 11.
